// File: rtl/rd_fwft_stage.sv
// Read-side FWFT output stage: turns the pointer controller's incr/empty interface and the
// registered memory read into a valid/ready stream. Optional pop counter: RD_FWFT_POPCNT_EN.
module rd_fwft_stage #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              rempty_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              rincr_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [1:0]        rd_level_o
`ifdef RD_FWFT_POPCNT_EN
    ,
    output logic [15:0]       rd_popcnt_o
`endif
);

    localparam logic [2:0] SkidMax = 3'(SKID_DEPTH);

    logic              init_q;
    logic              inflight_q;
    logic              head_q, head_d;
    logic              valid_q, valid_d;
    logic [1:0]        level_q, level_d;
    logic [DATA_W-1:0] mem_q [2];

    logic       pop;
    logic       push;
    logic       acc;
    logic       tail;
    logic [2:0] credit_sum;

    always_comb begin
        pop        = valid_q & m_ready_i;
        push       = inflight_q;
        // Slots already committed (held + in flight) after this cycle's pop.
        credit_sum = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};
        rincr_o    = ~init_q & ~rempty_i & (credit_sum < SkidMax);
        acc        = rincr_o & ~rempty_i;
        tail       = head_q ^ level_q[0];

        level_d = level_q;
        head_d  = head_q;
        unique case ({push, pop})
            2'b10: level_d = level_q + 2'd1;
            2'b01: begin
                level_d = level_q - 2'd1;
                head_d  = ~head_q;
            end
            2'b11: head_d = ~head_q;
            default: ;
        endcase
        valid_d = (level_d != 2'd0);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            init_q     <= 1'b1;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            valid_q    <= 1'b0;
            level_q    <= 2'd0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            init_q     <= 1'b0;
            inflight_q <= acc;
            head_q     <= head_d;
            valid_q    <= valid_d;
            level_q    <= level_d;
            if (push) begin
                mem_q[tail] <= rdata_i;
            end
        end
    end

    assign m_data_o   = mem_q[head_q];
    assign m_valid_o  = valid_q;
    assign rd_level_o = level_q;

`ifdef RD_FWFT_POPCNT_EN
    logic [15:0] popcnt_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            popcnt_q <= 16'd0;
        end else if (pop) begin
            popcnt_q <= popcnt_q + 16'd1;
        end
    end

    assign rd_popcnt_o = popcnt_q;
`endif

endmodule
